lt24_image_scanner: RTL and testbench

//  Raster pixel source feeding the LT24Display pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).

---
 rtl/lt24_pkg.sv | 23 ++
 rtl/lt24_raster_counter.sv | 66 ++++++
 rtl/lt24_image_scanner.sv | 136 +++++++++++++
 tb/tb_lt24_image_scanner.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_pkg.sv
// Shared types and defaults for the LT24 image scanner.
package lt24_pkg;

   typedef logic [15:0] pixel_t;  // RGB565

   localparam int unsigned LCD_WIDTH_DEFAULT  = 240;
   localparam int unsigned LCD_HEIGHT_DEFAULT = 320;
   localparam pixel_t      BACK_COLOR_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StPresent
   } state_t;

   // 10-bit compare so the window end sums cannot overflow
   function automatic logic in_window(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] x0, input logic [9:0] w,
                                      input logic [9:0] y0, input logic [9:0] h);
      return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
   endfunction

endpackage

// File: rtl/lt24_raster_counter.sv
// Row-major raster position with window flag and incremental ROM address.
module lt24_raster_counter
   import lt24_pkg::*;
#(
   parameter int unsigned LCD_WIDTH      = LCD_WIDTH_DEFAULT,
   parameter int unsigned LCD_HEIGHT     = LCD_HEIGHT_DEFAULT,
   parameter int unsigned PIC_X_START    = 10,
   parameter int unsigned PIC_Y_START    = 10,
   parameter int unsigned PIC_WIDTH      = 200,
   parameter int unsigned PIC_HEIGHT     = 270,
   parameter int unsigned ROM_ADDR_WIDTH = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      step,
   output logic [7:0]                x,
   output logic [8:0]                y,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   output logic                      in_win,
   output logic                      next_in_win,
   output logic                      last_pixel
);

   localparam logic [7:0] X_LAST = 8'(LCD_WIDTH - 1);
   localparam logic [8:0] Y_LAST = 9'(LCD_HEIGHT - 1);
   localparam logic [9:0] WIN_X0 = 10'(PIC_X_START);
   localparam logic [9:0] WIN_W  = 10'(PIC_WIDTH);
   localparam logic [9:0] WIN_Y0 = 10'(PIC_Y_START);
   localparam logic [9:0] WIN_H  = 10'(PIC_HEIGHT);
   localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_ONE = {{(ROM_ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [7:0] x_nxt;
   logic [8:0] y_nxt;

   // Next raster position with column and frame wrap
   always_comb begin
      x_nxt = x + 8'd1;
      y_nxt = y;
      if (x == X_LAST) begin
         x_nxt = '0;
         y_nxt = (y == Y_LAST) ? '0 : y + 9'd1;
      end
   end

   assign last_pixel  = (x == X_LAST) && (y == Y_LAST);
   assign in_win      = in_window({2'b00, x}, {1'b0, y}, WIN_X0, WIN_W, WIN_Y0, WIN_H);
   assign next_in_win = in_window({2'b00, x_nxt}, {1'b0, y_nxt}, WIN_X0, WIN_W, WIN_Y0, WIN_H);

   // Advance position; ROM address counts accepted window pixels, cleared at frame end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x        <= '0;
         y        <= '0;
         rom_addr <= '0;
      end else if (step) begin
         x <= x_nxt;
         y <= y_nxt;
         if (last_pixel) begin
            rom_addr <= '0;
         end else if (in_win) begin
            rom_addr <= rom_addr + ADDR_ONE;
         end
      end
   end

endmodule

// File: rtl/lt24_image_scanner.sv
// Raster pixel source for LT24Display: window pixels from a synchronous ROM, back colour elsewhere.
module lt24_image_scanner
   import lt24_pkg::*;
#(
   parameter int unsigned LCD_WIDTH      = LCD_WIDTH_DEFAULT,
   parameter int unsigned LCD_HEIGHT     = LCD_HEIGHT_DEFAULT,
   parameter int unsigned PIC_X_START    = 10,
   parameter int unsigned PIC_Y_START    = 10,
   parameter int unsigned PIC_WIDTH      = 200,
   parameter int unsigned PIC_HEIGHT     = 270,
   parameter int unsigned ROM_ADDR_WIDTH = 16,
   parameter int unsigned ROM_LATENCY    = 1,
   parameter pixel_t      BACK_COLOR     = BACK_COLOR_DEFAULT,
   parameter bit          CONTINUOUS     = 1'b1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   output logic [ROM_ADDR_WIDTH-1:0] romAddr,
   input  pixel_t                    romData,
   output logic [7:0]                xAddr,
   output logic [8:0]                yAddr,
   output pixel_t                    pixelData,
   output logic                      pixelWrite,
   input  logic                      pixelReady,
   output logic                      frameDone,
   output logic                      busy
);

   localparam int unsigned LAT_W = $clog2(ROM_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LATENCY);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   if (PIC_X_START + PIC_WIDTH > LCD_WIDTH) begin : g_bad_x
      $error("picture window exceeds LCD width");
   end
   if (PIC_Y_START + PIC_HEIGHT > LCD_HEIGHT) begin : g_bad_y
      $error("picture window exceeds LCD height");
   end
   if ((64'(PIC_WIDTH) * 64'(PIC_HEIGHT)) > (64'd1 << ROM_ADDR_WIDTH)) begin : g_bad_rom
      $error("picture does not fit the ROM address space");
   end
   if (LCD_WIDTH > 256 || LCD_HEIGHT > 512 || ROM_LATENCY < 1) begin : g_bad_geom
      $error("unsupported LCD size or ROM latency");
   end

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic             step;
   logic             in_win;
   logic             next_in_win;
   logic             last_pixel;

   // Pixel accepted by the display this cycle
   assign step = (state == StPresent) && pixelWrite && pixelReady;

   lt24_raster_counter #(
      .LCD_WIDTH      (LCD_WIDTH),
      .LCD_HEIGHT     (LCD_HEIGHT),
      .PIC_X_START    (PIC_X_START),
      .PIC_Y_START    (PIC_Y_START),
      .PIC_WIDTH      (PIC_WIDTH),
      .PIC_HEIGHT     (PIC_HEIGHT),
      .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
   ) u_raster (
      .clock       (clock),
      .reset       (reset),
      .step        (step),
      .x           (xAddr),
      .y           (yAddr),
      .rom_addr    (romAddr),
      .in_win      (in_win),
      .next_in_win (next_in_win),
      .last_pixel  (last_pixel)
   );

   // Scanner FSM with ROM wait counter and registered pixel outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         lat_cnt    <= '0;
         pixelData  <= BACK_COLOR;
         pixelWrite <= 1'b0;
         frameDone  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         case (state)
            StIdle: begin
               if (enable) begin
                  busy    <= 1'b1;
                  lat_cnt <= '0;
                  if (in_win) begin
                     state <= StFetch;
                  end else begin
                     state      <= StPresent;
                     pixelData  <= BACK_COLOR;
                     pixelWrite <= 1'b1;
                  end
               end
            end
            StFetch: begin
               // romAddr is held steady while the ROM read completes
               if (lat_cnt == LAT_LAST) begin
                  pixelData  <= romData;
                  pixelWrite <= 1'b1;
                  state      <= StPresent;
               end else begin
                  lat_cnt <= lat_cnt + LAT_ONE;
               end
            end
            StPresent: begin
               if (pixelReady) begin
                  lat_cnt <= '0;
                  if (last_pixel) begin
                     frameDone <= 1'b1;
                  end
                  if (last_pixel && !(CONTINUOUS || enable)) begin
                     state      <= StIdle;
                     pixelWrite <= 1'b0;
                     busy       <= 1'b0;
                  end else if (next_in_win) begin
                     state      <= StFetch;
                     pixelWrite <= 1'b0;
                  end else begin
                     // Background pixels stream back to back
                     pixelData <= BACK_COLOR;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lt24_image_scanner.sv
// Self-checking bench: a default-geometry scanner and a small-geometry one (ROM latency 3, one-shot).
module tb_lt24_image_scanner;

   localparam int A_W = 240, A_H = 320, A_X0 = 10, A_Y0 = 10, A_PW = 200, A_PH = 270, A_LAT = 1;
   localparam int S_W = 16, S_H = 12, S_X0 = 3, S_Y0 = 2, S_PW = 8, S_PH = 7, S_LAT = 3;
   localparam int G_W = 0, G_H = 1, G_X0 = 2, G_Y0 = 3, G_PW = 4, G_PH = 5, G_LAT = 6;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst_a, en_a, rdy_a, wr_a, fd_a, busy_a;
   logic [15:0] rom_addr_a, rom_data_a, data_a;
   logic [7:0]  x_a;
   logic [8:0]  y_a;
   logic        rst_s, en_s, rdy_s, wr_s, fd_s, busy_s;
   logic [15:0] rom_addr_s, rom_data_s, data_s, rom_p1_s, rom_p2_s;
   logic [7:0]  x_s;
   logic [8:0]  y_s;

   int checks = 0;
   int errors = 0;

   // Bench-side raster model state, one slot per scanner
   int          pos [2];
   int          gap [2];
   bit          gap_ok [2];
   bit          prev_last [2];
   bit          stall [2];
   logic [7:0]  sx [2];
   logic [8:0]  sy [2];
   logic [15:0] sd [2];

   // Image ROMs whose data equals the address
   always @(posedge clock) rom_data_a <= rom_addr_a;
   always @(posedge clock) begin
      rom_p1_s   <= rom_addr_s;
      rom_p2_s   <= rom_p1_s;
      rom_data_s <= rom_p2_s;
   end

   lt24_image_scanner #(
      .LCD_WIDTH (A_W), .LCD_HEIGHT (A_H), .PIC_X_START (A_X0), .PIC_Y_START (A_Y0),
      .PIC_WIDTH (A_PW), .PIC_HEIGHT (A_PH), .ROM_ADDR_WIDTH (16), .ROM_LATENCY (A_LAT),
      .BACK_COLOR (16'h0000), .CONTINUOUS (1'b1)
   ) dut_a (
      .clock (clock), .reset (rst_a), .enable (en_a), .romAddr (rom_addr_a),
      .romData (rom_data_a), .xAddr (x_a), .yAddr (y_a), .pixelData (data_a),
      .pixelWrite (wr_a), .pixelReady (rdy_a), .frameDone (fd_a), .busy (busy_a)
   );

   lt24_image_scanner #(
      .LCD_WIDTH (S_W), .LCD_HEIGHT (S_H), .PIC_X_START (S_X0), .PIC_Y_START (S_Y0),
      .PIC_WIDTH (S_PW), .PIC_HEIGHT (S_PH), .ROM_ADDR_WIDTH (16), .ROM_LATENCY (S_LAT),
      .BACK_COLOR (16'h0000), .CONTINUOUS (1'b0)
   ) dut_s (
      .clock (clock), .reset (rst_s), .enable (en_s), .romAddr (rom_addr_s),
      .romData (rom_data_s), .xAddr (x_s), .yAddr (y_s), .pixelData (data_s),
      .pixelWrite (wr_s), .pixelReady (rdy_s), .frameDone (fd_s), .busy (busy_s)
   );

   function automatic int geo(input bit s, input int k);
      int a [7];
      int b [7];
      a = '{A_W, A_H, A_X0, A_Y0, A_PW, A_PH, A_LAT};
      b = '{S_W, S_H, S_X0, S_Y0, S_PW, S_PH, S_LAT};
      return s ? b[k] : a[k];
   endfunction

   function automatic bit exp_in_win(input bit s, input int p);
      int px, py;
      px = p % geo(s, G_W);
      py = p / geo(s, G_W);
      return px >= geo(s, G_X0) && px < geo(s, G_X0) + geo(s, G_PW) &&
             py >= geo(s, G_Y0) && py < geo(s, G_Y0) + geo(s, G_PH);
   endfunction

   function automatic int exp_rom(input bit s, input int p);
      return (p / geo(s, G_W) - geo(s, G_Y0)) * geo(s, G_PW) + (p % geo(s, G_W) - geo(s, G_X0));
   endfunction

   function automatic logic [15:0] exp_data(input bit s, input int p);
      return exp_in_win(s, p) ? 16'(exp_rom(s, p)) : 16'h0000;
   endfunction

   task automatic model_restart(input bit s);
      pos[s]       = 0;
      gap[s]       = 0;
      gap_ok[s]    = 1'b0;
      prev_last[s] = 1'b0;
      stall[s]     = 1'b0;
   endtask

   // Drive pixelReady and check every presented pixel until pixel index stop_p is accepted
   task automatic run_scan(input bit s, input int stop_p, input bit rand_rdy, input int max_cyc,
                           output logic [15:0] last_data, output logic [15:0] last_rom,
                           output int accepts, output int pulses);
      bit          done;
      bit          r;
      int          w, n, want;
      logic [7:0]  ox;
      logic [8:0]  oy;
      logic [15:0] od, orom;
      logic        ow, ofd, ob;
      done = 1'b0; accepts = 0; pulses = 0; last_data = '0; last_rom = '0;
      w = geo(s, G_W);
      n = w * geo(s, G_H);
      for (int c = 0; c < max_cyc && !done; c++) begin
         @(negedge clock);
         ox = s ? x_s : x_a;           oy = s ? y_s : y_a;
         od = s ? data_s : data_a;     orom = s ? rom_addr_s : rom_addr_a;
         ow = s ? wr_s : wr_a;         ofd = s ? fd_s : fd_a;
         ob = s ? busy_s : busy_a;
         if (stall[s]) begin
            checks++;
            if (ow !== 1'b1 || ox !== sx[s] || oy !== sy[s] || od !== sd[s]) begin
               errors++;
               $display("FAIL stall_hold dut%0d: got w=%b (%0d,%0d) %h, want w=1 (%0d,%0d) %h",
                        s, ow, ox, oy, od, sx[s], sy[s], sd[s]);
            end
         end
         checks++;
         if (ofd !== prev_last[s]) begin
            errors++;
            $display("FAIL frame_done dut%0d: got %b want %b", s, ofd, prev_last[s]);
         end
         if (ofd === 1'b1) pulses++;
         if (ow === 1'b1) begin
            if (gap_ok[s]) begin
               want = exp_in_win(s, pos[s]) ? geo(s, G_LAT) + 1 : 0;
               checks++;
               if (gap[s] != want) begin
                  errors++;
                  $display("FAIL write_gap dut%0d pix %0d: got %0d idle cycles want %0d",
                           s, pos[s], gap[s], want);
               end
               gap_ok[s] = 1'b0;
            end
            checks++;
            if (ox !== 8'(pos[s] % w) || oy !== 9'(pos[s] / w) ||
                od !== exp_data(s, pos[s]) || ob !== 1'b1) begin
               errors++;
               $display("FAIL pixel dut%0d: got (%0d,%0d) %h busy=%b want (%0d,%0d) %h busy=1",
                        s, ox, oy, od, ob, pos[s] % w, pos[s] / w, exp_data(s, pos[s]));
            end
            if (exp_in_win(s, pos[s])) begin
               checks++;
               if (orom !== 16'(exp_rom(s, pos[s]))) begin
                  errors++;
                  $display("FAIL rom_addr dut%0d pix %0d: got %0d want %0d",
                           s, pos[s], orom, exp_rom(s, pos[s]));
               end
            end
         end else begin
            gap[s]++;
         end
         r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (s) rdy_s = r; else rdy_a = r;
         stall[s] = (ow === 1'b1) && !r;
         sx[s] = ox; sy[s] = oy; sd[s] = od;
         prev_last[s] = 1'b0;
         if (ow === 1'b1 && r) begin
            accepts++;
            last_data = od;
            last_rom  = orom;
            prev_last[s] = (pos[s] == n - 1);
            if (pos[s] == stop_p) done = 1'b1;
            pos[s] = (pos[s] + 1) % n;
            gap[s] = 0;
            gap_ok[s] = 1'b1;
         end
      end
      if (!done) begin
         errors++;
         $display("FAIL scan_timeout dut%0d: got pix %0d want pix %0d", s, pos[s], stop_p);
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
      rst_s = 1'b1; en_s = 1'b0; rdy_s = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({x_a, y_a, rom_addr_a, data_a, wr_a, fd_a, busy_a} !== 52'd0) begin
         errors++;
         $display("FAIL reset_a: got x=%0d y=%0d rom=%0d d=%h w=%b fd=%b busy=%b want all 0",
                  x_a, y_a, rom_addr_a, data_a, wr_a, fd_a, busy_a);
      end
      checks++;
      if ({x_s, y_s, rom_addr_s, data_s, wr_s, fd_s, busy_s} !== 52'd0) begin
         errors++;
         $display("FAIL reset_s: got x=%0d y=%0d rom=%0d d=%h w=%b fd=%b busy=%b want all 0",
                  x_s, y_s, rom_addr_s, data_s, wr_s, fd_s, busy_s);
      end
      model_restart(1'b0);
      model_restart(1'b1);
   endtask

   task automatic test_first_pixels();
      logic [15:0] d, r;
      int          n, p;
      @(negedge clock);
      rst_a = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (wr_a !== 1'b1 || x_a !== 8'd0 || y_a !== 9'd0 || data_a !== 16'h0000) begin
         errors++;
         $display("FAIL first_pixel: got w=%b (%0d,%0d) %h want w=1 (0,0) 0000",
                  wr_a, x_a, y_a, data_a);
      end
      run_scan(1'b0, 10 * A_W + 10, 1'b0, 20000, d, r, n, p);
      checks++;
      if (d !== 16'h0000 || r !== 16'd0) begin
         errors++; $display("FAIL pix_10_10: got %h rom %0d want 0000 rom 0", d, r);
      end
      run_scan(1'b0, 10 * A_W + 11, 1'b0, 100, d, r, n, p);
      checks++;
      if (d !== 16'h0001 || r !== 16'd1) begin
         errors++; $display("FAIL pix_11_10: got %h rom %0d want 0001 rom 1", d, r);
      end
      run_scan(1'b0, 11 * A_W + 10, 1'b0, 2000, d, r, n, p);
      checks++;
      if (d !== 16'h00C8 || r !== 16'd200) begin
         errors++; $display("FAIL pix_10_11: got %h rom %0d want 00c8 rom 200", d, r);
      end
   endtask

   task automatic test_random_ready_a();
      logic [15:0] d, r;
      int          n, p;
      run_scan(1'b0, 12 * A_W + 50, 1'b1, 20000, d, r, n, p);
      checks++;
      if (n != 280) begin
         errors++; $display("FAIL accept_count_a: got %0d want 280", n);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d, r;
      int          n, p;
      rst_a = 1'b1;
      #1;
      checks++;
      if ({x_a, y_a, rom_addr_a, data_a, wr_a, fd_a, busy_a} !== 52'd0) begin
         errors++;
         $display("FAIL mid_reset: got x=%0d y=%0d rom=%0d d=%h w=%b fd=%b busy=%b want all 0",
                  x_a, y_a, rom_addr_a, data_a, wr_a, fd_a, busy_a);
      end
      model_restart(1'b0);
      @(negedge clock);
      rst_a = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
      run_scan(1'b0, 10 * A_W + 10, 1'b0, 20000, d, r, n, p);
      checks++;
      if (r !== 16'd0 || n != 10 * A_W + 11) begin
         errors++;
         $display("FAIL restart_10_10: got rom %0d after %0d pixels want rom 0 after %0d",
                  r, n, 10 * A_W + 11);
      end
      run_scan(1'b0, 10 * A_W + 11, 1'b0, 100, d, r, n, p);
      checks++;
      if (d !== 16'h0001) begin
         errors++; $display("FAIL restart_11_10: got %h want 0001", d);
      end
   endtask

   task automatic test_latency();
      logic [15:0] d, r;
      int          n, p, cyc;
      bit          found;
      @(negedge clock);
      rst_s = 1'b0; en_s = 1'b1; rdy_s = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (wr_s !== 1'b1 || x_s !== 8'd0 || y_s !== 9'd0) begin
         errors++; $display("FAIL first_pixel_s: got w=%b (%0d,%0d) want w=1 (0,0)", wr_s, x_s, y_s);
      end
      run_scan(1'b1, 2 * S_W + 3, 1'b0, 2000, d, r, n, p);
      @(posedge clock);  // acceptance of (3,2)
      found = 1'b0; cyc = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         @(posedge clock); #1;
         if (wr_s === 1'b1) begin
            found = 1'b1; cyc = i;
         end
      end
      checks++;
      if (cyc != 4 || x_s !== 8'd4 || y_s !== 9'd2 || data_s !== 16'h0001) begin
         errors++;
         $display("FAIL latency3: got %0d cycles (%0d,%0d) %h want 4 cycles (4,2) 0001",
                  cyc, x_s, y_s, data_s);
      end
      gap_ok[1] = 1'b0;
   endtask

   task automatic test_full_frame();
      logic [15:0] d, r;
      int          n1, n2, p1, p2;
      run_scan(1'b1, S_W * S_H - 1, 1'b0, 5000, d, r, n1, p1);
      run_scan(1'b1, 8 * S_W + 10, 1'b0, 5000, d, r, n1, p1);
      checks++;
      if (r !== 16'(S_PW * S_PH - 1) || d !== 16'(S_PW * S_PH - 1)) begin
         errors++;
         $display("FAIL last_win_pix: got rom %0d data %h want %0d", r, d, S_PW * S_PH - 1);
      end
      run_scan(1'b1, S_W * S_H - 1, 1'b0, 5000, d, r, n2, p2);
      checks++;
      if (n1 + n2 != S_W * S_H || p1 + p2 != 1) begin
         errors++;
         $display("FAIL frame_count: got %0d accepts %0d pulses want %0d accepts 1 pulse",
                  n1 + n2, p1 + p2, S_W * S_H);
      end
   endtask

   task automatic test_drop_enable();
      logic [15:0] d, r;
      int          n, p;
      run_scan(1'b1, 7 * S_W + 10, 1'b1, 5000, d, r, n, p);
      en_s = 1'b0;
      run_scan(1'b1, S_W * S_H - 1, 1'b1, 5000, d, r, n, p);
      checks++;
      if (n != S_W * S_H - 1 - (7 * S_W + 10)) begin
         errors++;
         $display("FAIL drop_count: got %0d want %0d", n, S_W * S_H - 1 - (7 * S_W + 10));
      end
      @(negedge clock);
      checks++;
      if (fd_s !== 1'b1 || wr_s !== 1'b0 || busy_s !== 1'b0) begin
         errors++;
         $display("FAIL frame_end_idle: got fd=%b w=%b busy=%b want fd=1 w=0 busy=0",
                  fd_s, wr_s, busy_s);
      end
      repeat (5) @(negedge clock);
      checks++;
      if ({fd_s, wr_s, busy_s, x_s, y_s, rom_addr_s} !== 36'd0) begin
         errors++;
         $display("FAIL stay_idle: got fd=%b w=%b busy=%b (%0d,%0d) rom %0d want all 0",
                  fd_s, wr_s, busy_s, x_s, y_s, rom_addr_s);
      end
   endtask

   initial begin
      test_reset();
      test_first_pixels();
      test_random_ready_a();
      test_reset_mid_frame();
      test_latency();
      test_full_frame();
      test_drop_enable();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
